// File: rtl/pulse_voice_sched.sv
// pulse_voice_sched: shares one pulse-wave shaper across NVOICE voices.
// A free-running divider produces a sample tick. Each tick walks the voices
// in order, presents every enabled voice's phase/width to the shaper (one
// request per cycle), sums the shaper's registered replies and emits their
// average as one mix sample.
module pulse_voice_sched #(
  parameter int NVOICE = 4,
  parameter int DIV    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [$clog2(NVOICE)+1:0] addr,
  input  logic [31:0]               wdata,
  output logic                      sh_ena,
  output logic [31:0]               sh_phs,
  output logic [11:0]               sh_width,
  input  logic [15:0]               sh_out,
  input  logic                      sh_valid,
  output logic [15:0]               mix_out,
  output logic                      mix_valid,
  output logic                      ovf
);

  localparam int LOG2N = $clog2(NVOICE);
  localparam int CW    = $clog2(DIV);
  localparam int ACCW  = 16 + LOG2N;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [LOG2N-1:0] LAST_V  = LOG2N'(NVOICE - 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);

  // Host write decode
  logic [LOG2N-1:0] wr_voice;
  logic [1:0]       wr_sel;
  assign wr_voice = addr[LOG2N+1:2];
  assign wr_sel   = addr[1:0];

  // Divider / tick
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  // Sequencer state
  logic [1:0]             state_q, state_d;
  logic [LOG2N-1:0]       vidx_q, vidx_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] samp;
  logic                   mix_done;

  // Issue selection: which voice gets registered onto the shaper port next
  logic             issue_go;
  logic [LOG2N-1:0] issue_idx;
  logic             issue_en;

  // Per-voice state gathered for the issue mux
  logic [NVOICE-1:0][31:0] phase_all;
  logic [NVOICE-1:0][11:0] width_all;
  logic [NVOICE-1:0]       en_all;

  // Registered outputs
  logic        sh_ena_q;
  logic [31:0] sh_phs_q;
  logic [11:0] sh_width_q;
  logic [15:0] mix_out_q;
  logic        mix_valid_q;
  logic        ovf_q;

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  // Free-running sample divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Pick the voice to present next: voice 0 on the tick, then each following
  // voice while walking. Outputs are registered, so the choice is made one
  // cycle ahead of the cycle in which sh_ena is seen.
  always_comb begin
    issue_go  = 1'b0;
    issue_idx = '0;
    if (state_q == IDLE && tick) begin
      issue_go = 1'b1;
    end else if (state_q == RUN && vidx_q != LAST_V) begin
      issue_go  = 1'b1;
      issue_idx = vidx_q + LOG2N'(1);
    end
  end

  assign issue_en = issue_go && en_all[issue_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NVOICE; gi++) begin : g_voice
      logic        hit;
      logic [31:0] freq_q;
      logic [31:0] phase_q;
      logic [11:0] width_q;
      logic        en_q;

      assign hit = we && (wr_voice == LOG2N'(gi));

      // Voice registers; a phase-clear write beats the issue-time increment
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          freq_q  <= '0;
          phase_q <= '0;
          width_q <= '0;
          en_q    <= 1'b0;
        end else begin
          if (hit && wr_sel == 2'd0) freq_q  <= wdata;
          if (hit && wr_sel == 2'd1) width_q <= wdata[11:0];
          if (hit && wr_sel == 2'd2) en_q    <= wdata[0];
          if (hit && wr_sel == 2'd2 && wdata[1])
            phase_q <= '0;
          else if (issue_en && issue_idx == LOG2N'(gi))
            phase_q <= phase_q + freq_q;
        end
      end

      assign phase_all[gi] = phase_q;
      assign width_all[gi] = width_q;
      assign en_all[gi]    = en_q;
    end
  endgenerate

  // Shaper request port; phase/width hold their last value for idle voices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_ena_q   <= 1'b0;
      sh_phs_q   <= '0;
      sh_width_q <= '0;
    end else begin
      sh_ena_q <= issue_en;
      if (issue_en) begin
        sh_phs_q   <= phase_all[issue_idx];
        sh_width_q <= width_all[issue_idx];
      end
    end
  end

  assign samp = sh_valid ? {{LOG2N{sh_out[15]}}, sh_out} : '0;

  // Sequencer next state: IDLE -> RUN (one cycle per voice) -> DRAIN -> DONE.
  // DRAIN catches the last reply, which lags its request by one cycle.
  always_comb begin
    state_d  = state_q;
    vidx_d   = vidx_q;
    acc_d    = acc_q;
    mix_done = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (tick) begin
          state_d = RUN;
          vidx_d  = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + samp;
        if (vidx_q == LAST_V) state_d = DRAIN;
        else                  vidx_d  = vidx_q + LOG2N'(1);
      end
      DRAIN: begin
        acc_d    = acc_q + samp;
        state_d  = DONE;
        mix_done = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vidx_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      vidx_q  <= vidx_d;
      acc_q   <= acc_d;
    end
  end

  // Mix result is loaded as DRAIN ends so it is valid throughout DONE.
  // The sum of NVOICE 16-bit values always fits ACCW bits, and the shift
  // brings the average back into 16-bit range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= mix_done;
      if (mix_done) mix_out_q <= 16'(acc_d >>> LOG2N);
    end
  end

  // Sticky overrun: a tick arriving mid-sequence is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         ovf_q <= 1'b0;
    else if (tick && state_q != IDLE)  ovf_q <= 1'b1;
  end

  assign sh_ena    = sh_ena_q;
  assign sh_phs    = sh_phs_q;
  assign sh_width  = sh_width_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_voice_sched.sv
// Testbench for pulse_voice_sched: a model shaper answers requests one cycle
// later, and a per-voice reference model predicts every issue and mix value.
module tb_pulse_voice_sched;

  localparam int NV  = 4;
  localparam int DV  = 16;
  localparam int DV2 = NV + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (NVOICE=4, DIV=16)
  logic        reset, we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        sh_ena;
  logic [31:0] sh_phs;
  logic [11:0] sh_width;
  logic [15:0] sh_out   = 16'h0;
  logic        sh_valid = 1'b0;
  logic [15:0] mix_out;
  logic        mix_valid, ovf;

  // Overrun instance (DIV=NVOICE+1)
  logic        reset2, we2;
  logic [3:0]  addr2;
  logic [31:0] wdata2;
  logic        sh_ena2;
  logic [31:0] sh_phs2;
  logic [11:0] sh_width2;
  logic [15:0] sh_out2   = 16'h0;
  logic        sh_valid2 = 1'b0;
  logic [15:0] mix_out2;
  logic        mix_valid2, ovf2;

  pulse_voice_sched #(.NVOICE(NV), .DIV(DV)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .sh_ena(sh_ena), .sh_phs(sh_phs), .sh_width(sh_width),
    .sh_out(sh_out), .sh_valid(sh_valid),
    .mix_out(mix_out), .mix_valid(mix_valid), .ovf(ovf)
  );

  pulse_voice_sched #(.NVOICE(NV), .DIV(DV2)) dut_ovr (
    .clk(clk), .reset(reset2), .we(we2), .addr(addr2), .wdata(wdata2),
    .sh_ena(sh_ena2), .sh_phs(sh_phs2), .sh_width(sh_width2),
    .sh_out(sh_out2), .sh_valid(sh_valid2),
    .mix_out(mix_out2), .mix_valid(mix_valid2), .ovf(ovf2)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Shaper behaviour: high level while phase top bits are below width
  function automatic logic [15:0] shp(input logic [31:0] phs, input logic [11:0] w);
    return (phs[31:20] < w) ? 16'h7fff : 16'h8001;
  endfunction

  // Model shaper with one clock of latency
  logic        ena_dly = 1'b0;
  logic [15:0] out_dly = 16'h0;
  always @(negedge clk) begin
    sh_valid = ena_dly;
    sh_out   = out_dly;
    ena_dly  = sh_ena;
    out_dly  = shp(sh_phs, sh_width);
  end

  // Reference model of the voice registers
  logic [31:0] m_freq[NV];
  logic [31:0] m_phase[NV];
  logic [11:0] m_width[NV];
  logic        m_en[NV];

  logic [31:0] exp_p[$];
  logic [11:0] exp_w[$];
  logic [15:0] exp_mix;

  logic [31:0] obs_p[$];
  logic [11:0] obs_w[$];
  logic [15:0] obs_mix;
  bit          obs_seen;
  int          obs_cyc;

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_freq[v] = '0; m_phase[v] = '0; m_width[v] = '0; m_en[v] = 1'b0;
    end
  endtask

  // Expected requests and mix for the next tick; advances the model phases
  task automatic model_issue();
    int sum;
    sum = 0;
    exp_p.delete();
    exp_w.delete();
    for (int v = 0; v < NV; v++) begin
      if (m_en[v]) begin
        exp_p.push_back(m_phase[v]);
        exp_w.push_back(m_width[v]);
        sum += int'($signed(shp(m_phase[v], m_width[v])));
        m_phase[v] = m_phase[v] + m_freq[v];
      end
    end
    exp_mix = 16'(sum >>> 2);
  endtask

  // Register write (caller sits at a falling edge) plus model update
  task automatic wr(input logic [1:0] v, input logic [1:0] sel, input logic [31:0] d);
    we = 1'b1; addr = {v, sel}; wdata = d;
    @(negedge clk);
    we = 1'b0;
    case (sel)
      2'd0: m_freq[v]  = d;
      2'd1: m_width[v] = d[11:0];
      2'd2: begin m_en[v] = d[0]; if (d[1]) m_phase[v] = '0; end
      default: ;
    endcase
  endtask

  // Collect shaper requests until the next mix_valid, optionally injecting
  // one register write on cycle inj_cyc
  task automatic observe(input int inj_cyc, input logic [3:0] inj_addr, input logic [31:0] inj_data);
    obs_p.delete(); obs_w.delete();
    obs_seen = 0; obs_mix = '0; obs_cyc = 0;
    for (int c = 1; c <= 4 * DV; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin we = 1'b1; addr = inj_addr; wdata = inj_data; end
      else we = 1'b0;
      if (sh_ena) begin obs_p.push_back(sh_phs); obs_w.push_back(sh_width); end
      if (mix_valid) begin obs_seen = 1; obs_mix = mix_out; obs_cyc = c; break; end
    end
    we = 1'b0;
    $display("tick: issues=%0d mix_out=0x%04h after %0d cycles", obs_p.size(), obs_mix, obs_cyc);
  endtask

  task automatic test_reset();
    int c;
    bit saw_ena;
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    reset2 = 1'b1; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    vectors++;
    if ({sh_ena, sh_phs, sh_width, mix_out, mix_valid, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ena=%b phs=%h w=%h mix=%h mv=%b ovf=%b, want all 0",
               sh_ena, sh_phs, sh_width, mix_out, mix_valid, ovf);
    end
    reset = 1'b0;
    c = 0; saw_ena = 0;
    for (int k = 1; k <= 4 * DV; k++) begin
      @(negedge clk);
      if (sh_ena) saw_ena = 1;
      if (mix_valid) begin c = k; break; end
    end
    vectors++;
    if (c != DV + NV + 1 || mix_out !== 16'h0 || saw_ena) begin
      miscompares++;
      $display("FAIL reset_first_mix: got cycle=%0d mix=%h ena_seen=%0d, want cycle=%0d mix=0000 ena_seen=0",
               c, mix_out, saw_ena, DV + NV + 1);
    end
    $display("reset: first mix_valid at cycle %0d", c);
  endtask

  task automatic test_phase_seq();
    logic [31:0] want;
    wr(2'd0, 2'd0, 32'h1000_0000);
    wr(2'd0, 2'd2, 32'h3);
    for (int k = 0; k <= 16; k++) begin
      model_issue();
      observe(0, '0, '0);
      want = 32'(k) << 28;
      vectors++;
      if (!obs_seen || obs_p.size() != 1) begin
        miscompares++;
        $display("FAIL phase_seq[%0d] issue_count: got %0d (mix seen=%0d), want 1", k, obs_p.size(), obs_seen);
      end else if (obs_p[0] !== want) begin
        miscompares++;
        $display("FAIL phase_seq[%0d] sh_phs: got %h, want %h", k, obs_p[0], want);
      end
    end
  endtask

  task automatic test_mix_avg();
    wr(2'd0, 2'd1, 32'h800);
    wr(2'd1, 2'd1, 32'h800);
    wr(2'd2, 2'd1, 32'h0);
    wr(2'd3, 2'd1, 32'h800);
    for (int v = 0; v < NV; v++) wr(2'(v), 2'd2, 32'h3);
    model_issue();
    observe(0, '0, '0);
    vectors++;
    if (obs_p.size() != NV) begin
      miscompares++;
      $display("FAIL mix_avg issue_count: got %0d, want %0d", obs_p.size(), NV);
    end
    vectors++;
    if (!obs_seen || obs_mix !== 16'd16383 || exp_mix !== 16'd16383) begin
      miscompares++;
      $display("FAIL mix_avg mix_out: got %h (seen=%0d), want %h", obs_mix, obs_seen, 16'd16383);
    end
  endtask

  task automatic test_random();
    int nwr;
    for (int r = 0; r < 12; r++) begin
      nwr = $urandom_range(1, 8);
      for (int i = 0; i < nwr; i++)
        wr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
      model_issue();
      observe(0, '0, '0);
      vectors++;
      if (obs_p.size() != exp_p.size()) begin
        miscompares++;
        $display("FAIL random[%0d] issue_count: got %0d, want %0d", r, obs_p.size(), exp_p.size());
      end else begin
        foreach (exp_p[i]) begin
          vectors++;
          if (obs_p[i] !== exp_p[i] || obs_w[i] !== exp_w[i]) begin
            miscompares++;
            $display("FAIL random[%0d] issue%0d: got phs=%h w=%h, want phs=%h w=%h",
                     r, i, obs_p[i], obs_w[i], exp_p[i], exp_w[i]);
          end
        end
      end
      vectors++;
      if (!obs_seen || obs_mix !== exp_mix) begin
        miscompares++;
        $display("FAIL random[%0d] mix_out: got %h (seen=%0d), want %h", r, obs_mix, obs_seen, exp_mix);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] old2;
    wr(2'd0, 2'd2, 32'h1);
    wr(2'd1, 2'd2, 32'h1);
    wr(2'd2, 2'd2, 32'h3);
    wr(2'd3, 2'd2, 32'h1);
    wr(2'd2, 2'd0, 32'h0123_4567);
    for (int pass = 0; pass < 3; pass++) begin
      old2 = m_phase[2];
      model_issue();
      if (pass == 1) begin
        // Clear lands on the edge that issues voice 2: write wins
        m_phase[2] = '0;
        m_en[2]    = 1'b1;
        observe(12, 4'b1010, 32'h3);
      end else begin
        observe(0, '0, '0);
      end
      vectors++;
      if (obs_p.size() != NV) begin
        miscompares++;
        $display("FAIL collision[%0d] issue_count: got %0d, want %0d", pass, obs_p.size(), NV);
      end else begin
        foreach (exp_p[i]) begin
          vectors++;
          if (obs_p[i] !== exp_p[i] || obs_w[i] !== exp_w[i]) begin
            miscompares++;
            $display("FAIL collision[%0d] issue%0d: got phs=%h w=%h, want phs=%h w=%h",
                     pass, i, obs_p[i], obs_w[i], exp_p[i], exp_w[i]);
          end
        end
        vectors++;
        if (obs_p[2] !== ((pass == 2) ? 32'h0 : old2)) begin
          miscompares++;
          $display("FAIL collision[%0d] voice2_phs: got %h, want %h",
                   pass, obs_p[2], (pass == 2) ? 32'h0 : old2);
        end
      end
      vectors++;
      if (!obs_seen || obs_mix !== exp_mix) begin
        miscompares++;
        $display("FAIL collision[%0d] mix_out: got %h (seen=%0d), want %h", pass, obs_mix, obs_seen, exp_mix);
      end
    end
  endtask

  task automatic test_all_disabled();
    for (int v = 0; v < NV; v++) wr(2'(v), 2'd2, 32'h0);
    for (int k = 0; k < 4; k++) begin
      model_issue();
      observe(0, '0, '0);
      vectors++;
      if (!obs_seen || obs_p.size() != 0 || obs_mix !== 16'h0) begin
        miscompares++;
        $display("FAIL disabled[%0d]: got issues=%0d mix=%h seen=%0d, want issues=0 mix=0000 seen=1",
                 k, obs_p.size(), obs_mix, obs_seen);
      end
      if (k > 0) begin
        vectors++;
        if (obs_cyc != DV) begin
          miscompares++;
          $display("FAIL disabled[%0d] mix_period: got %0d, want %0d", k, obs_cyc, DV);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    bit saw_ena;
    int c;
    wr(2'd0, 2'd1, 32'h800);
    wr(2'd0, 2'd2, 32'h3);
    model_issue();
    observe(0, '0, '0);
    vectors++;
    if (!obs_seen || obs_mix !== exp_mix || exp_mix !== 16'h1fff) begin
      miscompares++;
      $display("FAIL rst_mid pre_mix: got %h, want %h", obs_mix, 16'h1fff);
    end
    found = 0;
    for (int k = 1; k <= 4 * DV; k++) begin
      @(negedge clk);
      if (sh_ena) begin found = 1; break; end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rst_mid wait_ena: got no sh_ena within %0d cycles, want one", 4 * DV);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({sh_ena, sh_phs, sh_width, mix_out, mix_valid, ovf} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid outputs: got ena=%b phs=%h w=%h mix=%h mv=%b ovf=%b, want all 0",
               sh_ena, sh_phs, sh_width, mix_out, mix_valid, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    c = 0; saw_ena = 0;
    for (int k = 1; k <= 4 * DV; k++) begin
      @(negedge clk);
      if (sh_ena) saw_ena = 1;
      if (mix_valid) begin c = k; break; end
    end
    vectors++;
    if (c != DV + NV + 1 || mix_out !== 16'h0 || saw_ena) begin
      miscompares++;
      $display("FAIL rst_mid first_mix: got cycle=%0d mix=%h ena_seen=%0d, want cycle=%0d mix=0000 ena_seen=0",
               c, mix_out, saw_ena, DV + NV + 1);
    end
    $display("reset mid-run: first mix_valid at cycle %0d", c);
  endtask

  task automatic test_overrun();
    int nmv;
    int first;
    nmv = 0; first = -1;
    @(negedge clk);
    reset2 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mix_valid2) begin nmv++; if (first < 0) first = c; end
      if (c == 9) begin
        vectors++;
        if (ovf2 !== 1'b0) begin
          miscompares++;
          $display("FAIL overrun before_2nd_tick: got ovf=%b, want 0", ovf2);
        end
      end
      if (c == 10 || c == 30) begin
        vectors++;
        if (ovf2 !== 1'b1) begin
          miscompares++;
          $display("FAIL overrun sticky@%0d: got ovf=%b, want 1", c, ovf2);
        end
      end
    end
    vectors++;
    if (first != 10 || nmv != 3 || mix_out2 !== 16'h0) begin
      miscompares++;
      $display("FAIL overrun mix_pulses: got first=%0d count=%0d mix=%h, want first=10 count=3 mix=0000",
               first, nmv, mix_out2);
    end
    $display("overrun: first mix_valid at cycle %0d, %0d pulses, ovf=%b", first, nmv, ovf2);
  endtask

  initial begin
    test_reset();
    test_phase_seq();
    test_mix_avg();
    test_random();
    test_collision();
    test_all_disabled();
    test_reset_mid_run();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
